alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Parametrised ALU controller with a multi-cycle sequencer for multiply/divide. Sits in the EX stage of the pipelined CPU. It decodes ALUOp/funct into the 4-bit ALU control word, as before. It also launches the iterative multiply/divide unit, stalls the pipeline for a fixed number of cycles, and issues the HI/LO write strobe on completion.

## Interface
Parameters:
- ALUOP_W, 3: width of ALUOp_i.
- FUNCT_W, 6: width of funct_i.
- CTRL_W, 4: width of ALUCtrl_o; must be ≥4.
- MUL_CYCLES, 4: multiply busy cycles N_M; must be ≥1.
- DIV_CYCLES, 32: divide busy cycles N_D; must be ≥1.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  EX stage holds a valid instruction.
- ALUOp_i  in  ALUOP_W  main-decoder ALU operation class.
- funct_i  in  FUNCT_W  R-type funct field.
- ALUCtrl_o  out  CTRL_W  ALU operation select (combinational).
- illegal_o  out  1  valid_i with an undefined ALUOp/funct (combinational).
- hilo_sel_o  out  2  01 = mfhi, 10 = mflo, 00 = none (combinational).
- md_start_o  out  1  one-cycle launch pulse to the mul/div unit.
- md_op_o  out  1  0 = mult, 1 = div; valid with md_start_o.
- stall_o  out  1  freeze PC, IF/ID and ID/EX.
- hilo_we_o  out  1  one-cycle HI/LO write enable.

## Operation
- ALUOp decode:
  - 000 → ADD 0010
  - 001 → SUB 0110
  - 010 → R-type, uses funct
  - 011 → AND 0000
  - 100 → OR 0001
  - 101 → SLT 0111
  - 110 → LUI 1010
  - 111 → illegal
- Funct decode (ALUOp 010):
  - 100000 → ADD 0010
  - 100010 → SUB 0110
  - 100100 → AND 0000
  - 100101 → OR 0001
  - 100111 → NOR 1100
  - 101010 → SLT 0111
  - 000000 → SLL 1000
  - 000010 → SRL 1001
  - 011000 → mult
  - 011010 → div
  - 010000 → mfhi
  - 010010 → mflo
  - any other funct → illegal
- mult, div, mfhi, mflo and illegal encodings drive ALUCtrl_o = 1111 (no-op). Upper bits are zero-extended when CTRL_W > 4.
- md_req = valid_i & ALUOp_i==010 & funct is mult or div.
- States:
  - IDLE: if md_req, assert md_start_o, load cnt = N−1, go to BUSY.
  - BUSY: stall_o=1. If cnt==0, go to DONE; else decrement cnt. Inputs are ignored.
  - DONE: assert hilo_we_o, stall_o=0. If md_req, behave as IDLE acceptance (back-to-back); else go to IDLE.
- N is N_M for mult and N_D for div. The op is latched into md_op_o at acceptance and held until the next acceptance.
- cnt width is $clog2(max(N_M, N_D)).

## Timing
- Acceptance cycle T:
  - md_start_o=1 and stall_o=1 combinationally in T.
  - stall_o=1 in cycles T+1 … T+N.
  - hilo_we_o=1 in T+N+1, with stall_o=0.
  - Total N+2 cycles from acceptance to the HI/LO write.
- stall_o = (state==IDLE|DONE) & md_req, OR state==BUSY.
- The decode outputs ALUCtrl_o, illegal_o and hilo_sel_o carry zero latency and are independent of state.
- Reset values:
  - state = IDLE, cnt = 0, md_op_o = 0.
  - md_start_o, stall_o and hilo_we_o are 0 while rst_i=1.
- Reset asserted mid-BUSY aborts the operation. No hilo_we_o is issued.
- valid_i=0 never starts an operation and forces illegal_o=0.

## Configuration
- ALU_CTRL_DIV_EN defined: div is decoded and sequenced as above.
- ALU_CTRL_DIV_EN undefined:
  - funct 011010 is treated as illegal: illegal_o=1, ALUCtrl_o=1111.
  - No start pulse and no stall.
  - md_op_o is tied to 0 and DIV_CYCLES is unused.

## Test plan
- ALUOp 010, funct 100111, valid → ALUCtrl_o=1100, illegal_o=0, stall_o=0; ALUOp 111 → illegal_o=1, ALUCtrl_o=1111.
- mult accepted at cycle 10 with MUL_CYCLES=4 → md_start_o at 10 only, stall_o at 10–14, hilo_we_o at 15 only, md_op_o=0.
- div (ALU_CTRL_DIV_EN defined, DIV_CYCLES=32) at cycle 0, then mult presented in the DONE cycle 33 → hilo_we_o and md_start_o both at 33, stall_o at 33–37, second hilo_we_o at 38.
- rst_i pulsed at T+2 during a mult → stall_o drops immediately, no hilo_we_o ever, state IDLE, next mult accepted normally.
- ALU_CTRL_DIV_EN undefined, div presented → illegal_o=1, stall_o=0, md_start_o=0; mflo → hilo_sel_o=10, ALUCtrl_o=1111.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control decode plus iterative mul/div sequencer.
// Define ALU_CTRL_DIV_EN to decode and sequence div (otherwise illegal).
module alu_ctrl_seq #(
  parameter int ALUOP_W    = 3,
  parameter int FUNCT_W    = 6,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               illegal_o,
  output logic [1:0]         hilo_sel_o,
  output logic               md_start_o,
  output logic               md_op_o,
  output logic               stall_o,
  output logic               hilo_we_o
);

`ifdef ALU_CTRL_DIV_EN
  localparam int MAX_N =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
`else
  localparam int MAX_N = MUL_CYCLES;
`endif
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
`ifdef ALU_CTRL_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ld_val;
  logic [3:0]       ctrl;
  logic             bad;
  logic             is_mul;
  logic             is_div;
  logic [1:0]       sel;
  logic             md_req;
  logic             accept;

  always_comb begin
    ctrl   = 4'b1111;
    bad    = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    sel    = 2'b00;
    case (ALUOp_i)
      ALUOP_W'(3'b000): ctrl = 4'b0010;
      ALUOP_W'(3'b001): ctrl = 4'b0110;
      ALUOP_W'(3'b011): ctrl = 4'b0000;
      ALUOP_W'(3'b100): ctrl = 4'b0001;
      ALUOP_W'(3'b101): ctrl = 4'b0111;
      ALUOP_W'(3'b110): ctrl = 4'b1010;
      ALUOP_W'(3'b010): begin
        case (funct_i)
          FUNCT_W'(6'b100000): ctrl = 4'b0010;
          FUNCT_W'(6'b100010): ctrl = 4'b0110;
          FUNCT_W'(6'b100100): ctrl = 4'b0000;
          FUNCT_W'(6'b100101): ctrl = 4'b0001;
          FUNCT_W'(6'b100111): ctrl = 4'b1100;
          FUNCT_W'(6'b101010): ctrl = 4'b0111;
          FUNCT_W'(6'b000000): ctrl = 4'b1000;
          FUNCT_W'(6'b000010): ctrl = 4'b1001;
          FUNCT_W'(6'b011000): is_mul = 1'b1;
`ifdef ALU_CTRL_DIV_EN
          FUNCT_W'(6'b011010): is_div = 1'b1;
`else
          FUNCT_W'(6'b011010): bad = 1'b1;
`endif
          FUNCT_W'(6'b010000): sel = 2'b01;
          FUNCT_W'(6'b010010): sel = 2'b10;
          default:             bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

  assign ALUCtrl_o  = CTRL_W'(ctrl);
  assign illegal_o  = valid_i & bad;
  assign hilo_sel_o = sel;

  assign md_req = valid_i & (is_mul | is_div);
  // rst_i gating keeps the launch pulse quiet while reset is held
  assign accept = md_req & (state != S_BUSY) & ~rst_i;

  assign md_start_o = accept;
  assign stall_o    = accept | (state == S_BUSY);
  assign hilo_we_o  = (state == S_DONE);

`ifdef ALU_CTRL_DIV_EN
  assign ld_val = is_div ? DIV_LD : MUL_LD;
  logic md_op_q;
  assign md_op_o = md_op_q;
`else
  assign ld_val  = MUL_LD;
  assign md_op_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
`ifdef ALU_CTRL_DIV_EN
      md_op_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (md_req) begin
            state <= S_BUSY;
            cnt   <= ld_val;
`ifdef ALU_CTRL_DIV_EN
            md_op_q <= is_div;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, mul/div sequencing,
// back-to-back acceptance and reset abort, with a HI/LO-write scoreboard.
module tb_alu_ctrl_seq;

  localparam int NM = 4;
  localparam int ND = 32;
  localparam logic [5:0] F_MUL  = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_MFLO = 6'b010010;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic [2:0] ALUOp_i = 3'b000;
  logic [5:0] funct_i = 6'b000000;
  logic [3:0] ALUCtrl_o;
  logic       illegal_o;
  logic [1:0] hilo_sel_o;
  logic       md_start_o;
  logic       md_op_o;
  logic       stall_o;
  logic       hilo_we_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];

  typedef struct packed {
    logic       v;
    logic [2:0] op;
    logic [5:0] f;
    logic [3:0] c;
    logic       il;
    logic [1:0] s;
  } vec_t;

  alu_ctrl_seq #(
    .ALUOP_W(3),
    .FUNCT_W(6),
    .CTRL_W(4),
    .MUL_CYCLES(NM),
    .DIV_CYCLES(ND)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .valid_i(valid_i),
    .ALUOp_i(ALUOp_i),
    .funct_i(funct_i),
    .ALUCtrl_o(ALUCtrl_o),
    .illegal_o(illegal_o),
    .hilo_sel_o(hilo_sel_o),
    .md_start_o(md_start_o),
    .md_op_o(md_op_o),
    .stall_o(stall_o),
    .hilo_we_o(hilo_we_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // every HI/LO write must match the oldest expected completion cycle
  always @(negedge clk_i) begin : mon
    int e;
    if (hilo_we_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL hilo_we_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e) begin
          bad++;
          $display("FAIL hilo_we_cycle got=%0d want=%0d", cyc, e);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [5:0] f);
    @(posedge clk_i);
    #1;
    valid_i = v;
    ALUOp_i = op;
    funct_i = f;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    valid_i = 1'b1;
    ALUOp_i = 3'b010;
    funct_i = F_MUL;
    repeat (2) @(negedge clk_i);
    total++;
    if (md_start_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_start got=%b want=0", md_start_o);
    end
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_stall got=%b want=0", stall_o);
    end
    total++;
    if (hilo_we_o !== 1'b0 || md_op_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_we_op got=%b%b want=00", hilo_we_o, md_op_o);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_decode();
    vec_t tbl[$];
    tbl.push_back({1'b1, 3'b010, 6'b100111, 4'b1100, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b111, 6'b000000, 4'b1111, 1'b1, 2'b00});
    tbl.push_back({1'b1, 3'b000, 6'b111111, 4'b0010, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b001, 6'b000000, 4'b0110, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b011, 6'b000000, 4'b0000, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b100, 6'b000000, 4'b0001, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b101, 6'b000000, 4'b0111, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b110, 6'b000000, 4'b1010, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b010, 6'b100000, 4'b0010, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b010, 6'b100010, 4'b0110, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b010, 6'b100100, 4'b0000, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b010, 6'b100101, 4'b0001, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b010, 6'b101010, 4'b0111, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b010, 6'b000000, 4'b1000, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b010, 6'b000010, 4'b1001, 1'b0, 2'b00});
    tbl.push_back({1'b1, 3'b010, 6'b010000, 4'b1111, 1'b0, 2'b01});
    tbl.push_back({1'b1, 3'b010, 6'b010010, 4'b1111, 1'b0, 2'b10});
    tbl.push_back({1'b1, 3'b010, 6'b111111, 4'b1111, 1'b1, 2'b00});
    tbl.push_back({1'b0, 3'b111, 6'b000000, 4'b1111, 1'b0, 2'b00});
    tbl.push_back({1'b0, 3'b010, 6'b011000, 4'b1111, 1'b0, 2'b00});
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].f);
      total++;
      if (ALUCtrl_o !== tbl[i].c) begin
        bad++;
        $display("FAIL dec_ctrl[%0d] got=%b want=%b", i, ALUCtrl_o,
                 tbl[i].c);
      end
      total++;
      if (illegal_o !== tbl[i].il) begin
        bad++;
        $display("FAIL dec_illegal[%0d] got=%b want=%b", i, illegal_o,
                 tbl[i].il);
      end
      total++;
      if (hilo_sel_o !== tbl[i].s) begin
        bad++;
        $display("FAIL dec_sel[%0d] got=%b want=%b", i, hilo_sel_o,
                 tbl[i].s);
      end
      total++;
      if (stall_o !== 1'b0 || md_start_o !== 1'b0) begin
        bad++;
        $display("FAIL dec_stall[%0d] got=%b%b want=00", i, stall_o,
                 md_start_o);
      end
    end
    drive(1'b0, 3'b000, 6'b000000);
  endtask

  task automatic busy_cycles(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      drive(1'b0, 3'b000, 6'b000000);
      total++;
      if (stall_o !== 1'b1 || md_start_o !== 1'b0 || hilo_we_o !== 1'b0)
      begin
        bad++;
        $display("FAIL %s_busy[%0d] got=%b%b%b want=100", tag, i, stall_o,
                 md_start_o, hilo_we_o);
      end
    end
  endtask

  task automatic test_mult();
    drive(1'b1, 3'b010, F_MUL);
    total++;
    if (md_start_o !== 1'b1 || stall_o !== 1'b1) begin
      bad++;
      $display("FAIL mul_accept got=%b%b want=11", md_start_o, stall_o);
    end
    exp_q.push_back(cyc + NM + 1);
    busy_cycles(NM, "mul");
    drive(1'b0, 3'b000, 6'b000000);
    total++;
    if (hilo_we_o !== 1'b1 || stall_o !== 1'b0 || md_op_o !== 1'b0) begin
      bad++;
      $display("FAIL mul_done got=%b%b%b want=100", hilo_we_o, stall_o,
               md_op_o);
    end
    drive(1'b0, 3'b000, 6'b000000);
    total++;
    if (hilo_we_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL mul_idle got=%b%b want=00", hilo_we_o, stall_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b010, F_MUL);
    exp_q.push_back(cyc + NM + 1);
    busy_cycles(NM, "b2b1");
    drive(1'b1, 3'b010, F_MUL);
    total++;
    if (hilo_we_o !== 1'b1 || md_start_o !== 1'b1 || stall_o !== 1'b1)
    begin
      bad++;
      $display("FAIL b2b_done_accept got=%b%b%b want=111", hilo_we_o,
               md_start_o, stall_o);
    end
    exp_q.push_back(cyc + NM + 1);
    busy_cycles(NM, "b2b2");
    drive(1'b0, 3'b000, 6'b000000);
    total++;
    if (hilo_we_o !== 1'b1 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done2 got=%b%b want=10", hilo_we_o, stall_o);
    end
    drive(1'b0, 3'b000, 6'b000000);
  endtask

`ifdef ALU_CTRL_DIV_EN
  task automatic test_div();
    drive(1'b1, 3'b010, F_DIV);
    total++;
    if (md_start_o !== 1'b1 || stall_o !== 1'b1 || illegal_o !== 1'b0)
    begin
      bad++;
      $display("FAIL div_accept got=%b%b%b want=110", md_start_o, stall_o,
               illegal_o);
    end
    exp_q.push_back(cyc + ND + 1);
    busy_cycles(ND, "div");
    total++;
    if (md_op_o !== 1'b1) begin
      bad++;
      $display("FAIL div_op got=%b want=1", md_op_o);
    end
    drive(1'b1, 3'b010, F_MUL);
    total++;
    if (hilo_we_o !== 1'b1 || md_start_o !== 1'b1 || stall_o !== 1'b1)
    begin
      bad++;
      $display("FAIL div_b2b got=%b%b%b want=111", hilo_we_o, md_start_o,
               stall_o);
    end
    exp_q.push_back(cyc + NM + 1);
    busy_cycles(NM, "div_mul");
    total++;
    if (md_op_o !== 1'b0) begin
      bad++;
      $display("FAIL div_mul_op got=%b want=0", md_op_o);
    end
    drive(1'b0, 3'b000, 6'b000000);
    drive(1'b0, 3'b000, 6'b000000);
  endtask
`else
  task automatic test_div();
    drive(1'b1, 3'b010, F_DIV);
    total++;
    if (illegal_o !== 1'b1 || ALUCtrl_o !== 4'b1111) begin
      bad++;
      $display("FAIL div_off_illegal got=%b/%b want=1/1111", illegal_o,
               ALUCtrl_o);
    end
    total++;
    if (stall_o !== 1'b0 || md_start_o !== 1'b0) begin
      bad++;
      $display("FAIL div_off_start got=%b%b want=00", stall_o, md_start_o);
    end
    drive(1'b1, 3'b010, F_MFLO);
    total++;
    if (hilo_sel_o !== 2'b10 || ALUCtrl_o !== 4'b1111 || stall_o !== 1'b0)
    begin
      bad++;
      $display("FAIL div_off_mflo got=%b/%b/%b want=10/1111/0", hilo_sel_o,
               ALUCtrl_o, stall_o);
    end
    drive(1'b0, 3'b000, 6'b000000);
  endtask
`endif

  task automatic test_rst_abort();
    drive(1'b1, 3'b010, F_MUL);
    exp_q.push_back(cyc + NM + 1);
    drive(1'b0, 3'b000, 6'b000000);
    total++;
    if (stall_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre got=%b want=1", stall_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_stall got=%b want=0", stall_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < NM + 3; i++) begin
      drive(1'b0, 3'b000, 6'b000000);
      total++;
      if (hilo_we_o !== 1'b0 || stall_o !== 1'b0) begin
        bad++;
        $display("FAIL abort_idle[%0d] got=%b%b want=00", i, hilo_we_o,
                 stall_o);
      end
    end
    test_mult();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_back_to_back();
    test_div();
    test_rst_abort();
    repeat (2) @(negedge clk_i);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL hilo_we_missing got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
